// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID pipeline register
//
// Fetches 16-bit instructions from instruction memory over a req/ack
// handshake and presents one instruction per cycle to the decoder. It
// handles three downstream events: a decode stall, using a one-entry skid
// buffer; a branch redirect, which flushes IF/ID; and a redirect that
// arrives while a request is still in flight.
//
// Optional build macro: FETCH_PERF_CNT_EN adds saturating stall, redirect
// and drop counters.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   imem_req          fetch request to instruction memory
//   imem_addr         word address of the request (the PC)
//   imem_rdata        instruction word, valid when imem_ack=1
//   imem_ack          request completes this cycle
//   stall             decode cannot accept; IF/ID holds
//   br_taken          redirect pulse
//   br_target         redirect address
//   instruction       IF/ID instruction to decode (NOP_INSTR when invalid)
//   pc_plus1          address of the held instruction plus 1
//   if_valid          instruction holds a real fetched word
//   perf_*_cnt        (FETCH_PERF_CNT_EN only) saturating event counters

module fetch_stage #(
    parameter int              PC_W      = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [15:0]     NOP_INSTR = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ack,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic [15:0]     instruction,
    output logic [PC_W-1:0] pc_plus1,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]     perf_stall_cnt,
    output logic [15:0]     perf_redirect_cnt,
    output logic [15:0]     perf_drop_cnt,
`endif
    output logic            if_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUF  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    // While a squashed request drains in DROP, pc (and so imem_addr) must
    // stay on the old address. The redirect target waits here until the ack.
    logic [PC_W-1:0] redir_pc;
    // The skid buffer is full exactly when state == S_BUF.
    logic [15:0]     skid_instr;
    logic [PC_W-1:0] skid_pc1;
    // A redirect with no ack leaves a request in flight that must drain.
    logic            redir_pending;

    assign pc_inc        = pc + PC_W'(1);
    assign imem_addr     = pc;
    assign redir_pending = (state == S_REQ || state == S_DROP) && !imem_ack;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect takes priority over stall and ack
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (br_taken) begin
                    state_nxt = imem_ack ? S_REQ : S_DROP;
                end else if (imem_ack && stall) begin
                    state_nxt = S_BUF;
                end
            end
            S_BUF: begin
                if (br_taken || !stall) begin
                    state_nxt = S_REQ;
                end
            end
            // A redirect alongside the draining ack goes straight to the
            // new target; without an ack, DROP keeps waiting.
            S_DROP: begin
                if (imem_ack) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req = (state == S_REQ) || (state == S_DROP);
    end

    // PC, IF/ID register and skid buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            redir_pc    <= RESET_PC;
            instruction <= NOP_INSTR;
            pc_plus1    <= '0;
            if_valid    <= 1'b0;
            skid_instr  <= NOP_INSTR;
            skid_pc1    <= '0;
        end else if (br_taken) begin
            instruction <= NOP_INSTR;
            if_valid    <= 1'b0;
            if (redir_pending) begin
                redir_pc <= br_target;
            end else begin
                pc <= br_target;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ack) begin
                        pc <= pc_inc;
                        if (!stall) begin
                            instruction <= imem_rdata;
                            pc_plus1    <= pc_inc;
                            if_valid    <= 1'b1;
                        end else begin
                            skid_instr <= imem_rdata;
                            skid_pc1   <= pc_inc;
                        end
                    end else if (!stall) begin
                        instruction <= NOP_INSTR;
                        if_valid    <= 1'b0;
                    end
                end
                S_BUF: begin
                    if (!stall) begin
                        instruction <= skid_instr;
                        pc_plus1    <= skid_pc1;
                        if_valid    <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        pc <= redir_pc;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic drop_evt;

    assign drop_evt = imem_ack &&
                      ((state == S_DROP) || (state == S_REQ && br_taken));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
            perf_drop_cnt     <= '0;
        end else begin
            if (stall && if_valid && perf_stall_cnt != 16'hFFFF) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
            if (br_taken && perf_redirect_cnt != 16'hFFFF) begin
                perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
            end
            if (drop_evt && perf_drop_cnt != 16'hFFFF) begin
                perf_drop_cnt <= perf_drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
